// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: handshake and line signals of the serial frame transmitter.
//   data  : parallel word offered to the transmitter
//   valid : data is valid this cycle
//   ready : transmitter can accept a word this cycle
//   tx    : serial line, idles high
//   busy  : a frame is in progress
//   done  : one-cycle pulse when a frame completes
// master = word source, slave = transmitter.
interface serial_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (output data, valid, input ready, tx, busy, done);
  modport slave  (input data, valid, output ready, tx, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks. All outputs are flip-flops.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : serial_frame_tx_if slave (data/valid in; ready/tx/busy/done out)
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_EN = 1)
// STOP   | stop bit (1); next cycle is IDLE with done pulse
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  serial_frame_tx_if.slave      bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic                  par_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);
  // Shifted word; its bit 0 is the next data bit to drive.
  assign shreg_d  = shreg_q >> 1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.valid && ready_q) begin
            shreg_q <= bus.data;
            par_q   <= (^bus.data) ^ (PARITY_ODD != 0);
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        START: begin
          if (cnt_last) begin
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end
        end
        DATA: begin
          if (cnt_last) begin
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shreg_d;
              tx_q    <= shreg_d[0];
            end
          end
        end
        PARITY: begin
          if (cnt_last) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  tx, busy, ready, done;
  logic [15:0] data [4];

  int checks   = 0;
  int failures = 0;

  // Instance k: 0 = (8,4,even), 1 = (8,4,odd), 2 = (8,4,no parity), 3 = (1,1,even)
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus0 ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus1 ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus2 ();
  serial_frame_tx_if #(.DATA_WIDTH(1)) bus3 ();

  assign bus0.data = data[0][7:0];  assign bus0.valid = valid[0];
  assign bus1.data = data[1][7:0];  assign bus1.valid = valid[1];
  assign bus2.data = data[2][7:0];  assign bus2.valid = valid[2];
  assign bus3.data = data[3][0:0];  assign bus3.valid = valid[3];

  assign tx[0] = bus0.tx;  assign busy[0] = bus0.busy;  assign ready[0] = bus0.ready;  assign done[0] = bus0.done;
  assign tx[1] = bus1.tx;  assign busy[1] = bus1.busy;  assign ready[1] = bus1.ready;  assign done[1] = bus1.done;
  assign tx[2] = bus2.tx;  assign busy[2] = bus2.busy;  assign ready[2] = bus2.ready;  assign done[2] = bus2.done;
  assign tx[3] = bus3.tx;  assign busy[3] = bus3.busy;  assign ready[3] = bus3.ready;  assign done[3] = bus3.done;

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1))
    u_dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));
  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus2));
  serial_frame_tx #(.DATA_WIDTH(1), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut3 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus3));

  function automatic int cfg_dw(input int k);  return (k == 3) ? 1 : 8; endfunction
  function automatic int cfg_cpb(input int k); return (k == 3) ? 1 : 4; endfunction
  function automatic int cfg_pe(input int k);  return (k == 2) ? 0 : 1; endfunction
  function automatic int cfg_po(input int k);  return (k == 1) ? 1 : 0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called on a falling edge. Offers word w to instance k, then checks every
  // line cycle against a bit list built from the framing rules.
  task automatic run_frame(input int k, input logic [15:0] w, input bit toggle,
                           input bit hold, input logic [15:0] next_w);
    int dw, cpb, pe, po;
    bit p;
    bit exp_q[$];
    dw  = cfg_dw(k);
    cpb = cfg_cpb(k);
    pe  = cfg_pe(k);
    po  = cfg_po(k);
    p   = (po != 0);
    for (int i = 0; i < dw; i++) p ^= w[i];
    repeat (cpb) exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) repeat (cpb) exp_q.push_back(w[i]);
    if (pe != 0) repeat (cpb) exp_q.push_back(p);
    repeat (cpb) exp_q.push_back(1'b1);

    data[k]  = w;
    valid[k] = 1'b1;
    chk("ready_before_accept", ready[k], 1);
    @(posedge clk);
    @(negedge clk);
    valid[k] = hold;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("tx[k%0d,c%0d]", k, i + 1), tx[k], exp_q[i]);
      chk("busy_in_frame", busy[k], 1);
      chk("ready_in_frame", ready[k], 0);
      chk("done_in_frame", done[k], 0);
      if (toggle) data[k] = 16'($urandom);
    end
    @(negedge clk);
    chk("done_pulse", done[k], 1);
    chk("ready_after", ready[k], 1);
    chk("busy_after", busy[k], 0);
    chk("tx_idle_gap", tx[k], 1);
    if (hold) begin
      data[k] = next_w;
    end else begin
      valid[k] = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done[k], 0);
      chk("tx_idle", tx[k], 1);
      chk("busy_idle", busy[k], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    valid = 4'hF;
    for (int i = 0; i < 4; i++) data[i] = 16'hFFFF;

    // reset held with Valid asserted
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("rst_tx", tx[i], 1);
        chk("rst_ready", ready[i], 1);
        chk("rst_busy", busy[i], 0);
        chk("rst_done", done[i], 0);
      end
    end
    valid = 4'h0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("post_rst_tx", tx[i], 1);
        chk("post_rst_busy", busy[i], 0);
      end
    end

    // directed frames
    run_frame(0, 16'h00A5, 1'b0, 1'b0, 16'h0);
    run_frame(1, 16'h0007, 1'b0, 1'b0, 16'h0);
    run_frame(2, 16'h0007, 1'b0, 1'b0, 16'h0);
    run_frame(3, 16'h0001, 1'b0, 1'b0, 16'h0);

    // back-to-back with Valid held and Data_in toggling during the first frame
    run_frame(0, 16'h003C, 1'b1, 1'b1, 16'h00C3);
    run_frame(0, 16'h00C3, 1'b0, 1'b0, 16'h0);

    // reset in the middle of DATA (cycle 17 = data bit 3 of 0x55, a 0)
    data[0]  = 16'h0055;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_tx_before_rst", tx[0], 0);
    chk("mid_busy_before_rst", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx[0], 1);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_ready", ready[0], 1);
    chk("async_rst_done", done[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_rst", done[0], 0);
      chk("idle_after_rst", tx[0], 1);
    end
    run_frame(0, 16'h0012, 1'b0, 1'b0, 16'h0);

    // randomized frames across all configurations
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        logic [15:0] w2;
        w2 = 16'($urandom);
        run_frame(k, 16'($urandom), 1'b1, 1'b1, w2);
        run_frame(k, w2, 1'b0, 1'b0, 16'h0);
      end else begin
        run_frame(k, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 16'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
